par_chk_serial: RTL and testbench



---
 rtl/par_chk_serial_if.sv | 23 ++
 rtl/par_chk_serial.sv | 62 ++++++
 tb/tb_par_chk_serial.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/par_chk_serial_if.sv
// par_chk_serial_if: control/status bundle between the RX FSM (master) and the parity checker (slave).
// PAR_ERR_CNT_EN adds the saturating error counter and its clear.
interface par_chk_serial_if
`ifdef PAR_ERR_CNT_EN
  #(parameter int CNT_WIDTH = 8)
`endif
  ;
  logic par_en, par_typ, start_chk, bit_valid, par_chk_en, sampled_bit;
  logic par_err, par_done;
`ifdef PAR_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] err_cnt;
  logic err_cnt_clr;
  modport master (output par_en, par_typ, start_chk, bit_valid, par_chk_en, sampled_bit, err_cnt_clr,
                  input par_err, par_done, err_cnt);
  modport slave (input par_en, par_typ, start_chk, bit_valid, par_chk_en, sampled_bit, err_cnt_clr,
                 output par_err, par_done, err_cnt);
`else
  modport master (output par_en, par_typ, start_chk, bit_valid, par_chk_en, sampled_bit,
                  input par_err, par_done);
  modport slave (input par_en, par_typ, start_chk, bit_valid, par_chk_en, sampled_bit,
                 output par_err, par_done);
`endif
endinterface

// File: rtl/par_chk_serial.sv
// par_chk_serial: serial even/odd parity checker with registered error flag and done pulse.
// PAR_ERR_CNT_EN adds a saturating error counter (err_cnt) with synchronous clear.
module par_chk_serial #(
  parameter int DATA_WIDTH = 8
`ifdef PAR_ERR_CNT_EN
  , parameter int CNT_WIDTH = 8
`endif
) (
  input logic clk,
  input logic rst,
  par_chk_serial_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, WAIT_PAR = 2'd2;
  logic [1:0] state;
  logic [BW-1:0] cnt;
  logic acc, typ;
  logic active, fire, err_val, err_inc;
  // start_chk and a falling par_en both pre-empt any strobe in the same cycle
  always_comb begin
    active = bus.par_en && !bus.start_chk;
    fire = active && bus.par_chk_en && (state == ACC || state == WAIT_PAR);
    err_val = (state == ACC) ? 1'b1 : (bus.sampled_bit != (acc ^ typ));
    err_inc = fire && err_val;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= 1'b0;
      typ <= 1'b0;
      bus.par_err <= 1'b0;
      bus.par_done <= 1'b0;
    end else begin
      bus.par_done <= fire;
      if (!bus.par_en) begin
        state <= IDLE;
      end else if (bus.start_chk) begin
        state <= ACC;
        cnt <= '0;
        acc <= 1'b0;
        typ <= bus.par_typ;
        bus.par_err <= 1'b0;
      end else if (fire) begin
        state <= IDLE;
        bus.par_err <= err_val;
      end else if (state == ACC && bus.bit_valid) begin
        acc <= acc ^ bus.sampled_bit;
        cnt <= cnt + 1'b1;
        state <= (cnt == LAST) ? WAIT_PAR : ACC;
      end
    end
  end
`ifdef PAR_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.err_cnt <= '0;
    else bus.err_cnt <= bus.err_cnt_clr ? CNT_WIDTH'(err_inc) :
                        (err_inc && bus.err_cnt != '1) ? bus.err_cnt + 1'b1 : bus.err_cnt;
  end
`endif
endmodule

// File: tb/tb_par_chk_serial.sv
// tb_par_chk_serial: directed checks of par_chk_serial at DATA_WIDTH 8 and 7 driven in lockstep.
// Define PAR_ERR_CNT_EN to include the error-counter checks (CNT_WIDTH=2).
module tb_par_chk_serial;
  logic clk = 1'b0, rst = 1'b0;
  logic par_en = 1'b0, par_typ = 1'b0, start_chk = 1'b0, bit_valid = 1'b0, par_chk_en = 1'b0, sampled_bit = 1'b0;
  logic err_cnt_clr = 1'b0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
`ifdef PAR_ERR_CNT_EN
  par_chk_serial_if #(.CNT_WIDTH(2)) b8 ();
  par_chk_serial_if #(.CNT_WIDTH(2)) b7 ();
  par_chk_serial #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  par_chk_serial #(.DATA_WIDTH(7), .CNT_WIDTH(2)) dut7 (.clk(clk), .rst(rst), .bus(b7));
  assign b8.err_cnt_clr = err_cnt_clr;
  assign b7.err_cnt_clr = err_cnt_clr;
`else
  par_chk_serial_if b8 ();
  par_chk_serial_if b7 ();
  par_chk_serial #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  par_chk_serial #(.DATA_WIDTH(7)) dut7 (.clk(clk), .rst(rst), .bus(b7));
`endif
  assign b8.par_en = par_en;
  assign b7.par_en = par_en;
  assign b8.par_typ = par_typ;
  assign b7.par_typ = par_typ;
  assign b8.start_chk = start_chk;
  assign b7.start_chk = start_chk;
  assign b8.bit_valid = bit_valid;
  assign b7.bit_valid = bit_valid;
  assign b8.par_chk_en = par_chk_en;
  assign b7.par_chk_en = par_chk_en;
  assign b8.sampled_bit = sampled_bit;
  assign b7.sampled_bit = sampled_bit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic t);
    start_chk = 1'b1;
    par_typ = t;
    step();
    start_chk = 1'b0;
  endtask
  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      sampled_bit = d[i];
      step();
    end
    bit_valid = 1'b0;
  endtask
  task automatic parity(input logic b);
    par_chk_en = 1'b1;
    sampled_bit = b;
    step();
    par_chk_en = 1'b0;
  endtask

  initial begin
    par_en = 1'b1;
    step();
    step();
    chk("reset_err", b8.par_err, 1'b0);
    chk("reset_done", b8.par_done, 1'b0);
`ifdef PAR_ERR_CNT_EN
    chk("reset_cnt", b8.err_cnt, 2'd0);
`endif
    rst = 1'b1;
    step();
    // even parity, A5 has four ones, parity bit 0 is correct
    start(1'b0);
    send_bits(8'hA5, 8);
    chk("even_ok_pre_done", b8.par_done, 1'b0);
    parity(1'b0);
    chk("even_ok_done", b8.par_done, 1'b1);
    chk("even_ok_err", b8.par_err, 1'b0);
    // back-to-back: odd parity on the same data, parity bit 0 is wrong
    start(1'b1);
    chk("done_one_cycle", b8.par_done, 1'b0);
    send_bits(8'hA5, 8);
    parity(1'b0);
    chk("odd_bad_done", b8.par_done, 1'b1);
    chk("odd_bad_err", b8.par_err, 1'b1);
    step();
    step();
    chk("odd_bad_err_hold", b8.par_err, 1'b1);
    chk("odd_bad_done_low", b8.par_done, 1'b0);
    start(1'b0);
    chk("start_clears_err", b8.par_err, 1'b0);
    // early parity after 5 bits
    start(1'b0);
    send_bits(8'h1F, 5);
    parity(1'b0);
    chk("early7_done", b7.par_done, 1'b1);
    chk("early7_err", b7.par_err, 1'b1);
    chk("early8_err", b8.par_err, 1'b1);
    parity(1'b0);
    chk("idle_ignore_done", b7.par_done, 1'b0);
    chk("idle_ignore_err", b7.par_err, 1'b1);
    // asynchronous reset clears outputs without waiting for an edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_err", b8.par_err, 1'b0);
    step();
    rst = 1'b1;
    // reset mid-frame, then odd parity on 8'h01 with parity bit 0
    start(1'b1);
    send_bits(8'h07, 3);
    rst = 1'b0;
    #1;
    chk("midrst_done", b8.par_done, 1'b0);
    step();
    rst = 1'b1;
    start(1'b1);
    send_bits(8'h01, 8);
    parity(1'b0);
    chk("after_rst_done", b8.par_done, 1'b1);
    chk("after_rst_err", b8.par_err, 1'b0);
    // start_chk with a coincident bit_valid: the bit must not count
    start_chk = 1'b1;
    par_typ = 1'b0;
    bit_valid = 1'b1;
    sampled_bit = 1'b1;
    step();
    start_chk = 1'b0;
    bit_valid = 1'b0;
    send_bits(8'hFF, 8);
    parity(1'b0);
    chk("coinc_ff_done", b8.par_done, 1'b1);
    chk("coinc_ff_err", b8.par_err, 1'b0);
    start_chk = 1'b1;
    bit_valid = 1'b1;
    sampled_bit = 1'b1;
    step();
    start_chk = 1'b0;
    bit_valid = 1'b0;
    send_bits(8'hFF, 7);
    parity(1'b0);
    chk("coinc_7bits_early", b8.par_err, 1'b1);
    // par_en drop mid-frame: back to IDLE, no pulse, par_err untouched
    start(1'b0);
    send_bits(8'h03, 3);
    par_en = 1'b0;
    step();
    chk("paren_drop_done", b8.par_done, 1'b0);
    chk("paren_drop_err", b8.par_err, 1'b0);
    par_en = 1'b1;
    send_bits(8'h1F, 5);
    parity(1'b0);
    chk("paren_idle_done", b8.par_done, 1'b0);
`ifdef PAR_ERR_CNT_EN
    // counter starts at 1 from the odd_bad/early/coinc errors? reset cleared it; count from here
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    chk("cnt_clr0", b8.err_cnt, 2'd0);
    for (int f = 0; f < 5; f++) begin
      start(1'b0);
      send_bits(8'h00, 8);
      parity(1'b1);
      chk($sformatf("cnt_frame%0d", f), b8.err_cnt, (f < 3) ? 2'(f + 1) : 2'd3);
    end
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    chk("cnt_clr", b8.err_cnt, 2'd0);
    start(1'b0);
    send_bits(8'h00, 8);
    step();
    err_cnt_clr = 1'b1;
    parity(1'b1);
    err_cnt_clr = 1'b0;
    chk("cnt_clr_and_inc", b8.err_cnt, 2'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
